// File: rtl/rx_sync_fsm.sv
// rx_sync_fsm: receive-side phase-alignment sequencer for a GTX lane running
// with the RX elastic buffer bypassed. Sequences the delay-aligner reset, a
// wait period and PMA phase alignment, then holds SYNC_DONE. Loss of reset-done
// or a resync request restarts the sequence; exits from Ready are counted.
module rx_sync_fsm #(
    parameter int unsigned ALIGN_CNT = 20,
    parameter int unsigned WAIT_CNT  = 32,
    parameter int unsigned SYNC_CNT  = 8192
) (
    input  logic       CLK,
    input  logic       RST_B,
    input  logic       RXRESETDONE,
    input  logic       RESYNC,
    output logic       SYNC_DONE,
    output logic       RXDLYALIGNRESET,
    output logic       RXENPMAPHASEALIGN,
    output logic       RXPMASETPHASE,
    output logic [7:0] RESYNC_CNT
);

    typedef enum logic [2:0] {
        ST_IDLE              = 3'd0,
        ST_ALIGN_RESET       = 3'd1,
        ST_WAIT_B4_SET_PHASE = 3'd2,
        ST_PHASE_ALIGN       = 3'd3,
        ST_READY             = 3'd4
    } state_e;

    localparam logic [4:0]  ALIGN_LIM = 5'(ALIGN_CNT);
    localparam logic [5:0]  WAIT_LIM  = 6'(WAIT_CNT);
    localparam logic [15:0] SYNC_LIM  = 16'(SYNC_CNT);

    state_e      state_q, state_d;
    logic        rd_s1_q, rd_s1_d;
    logic        rd_s2_q, rd_s2_d;
    logic [4:0]  acnt_q, acnt_d;
    logic [5:0]  wcnt_q, wcnt_d;
    logic [15:0] scnt_q, scnt_d;
    logic        sync_done_q, sync_done_d;
    logic        dly_rst_q, dly_rst_d;
    logic        en_pma_q, en_pma_d;
    logic        set_phase_q, set_phase_d;
    logic [7:0]  resync_cnt_q, resync_cnt_d;

    // Two-flop synchronizer for the asynchronous reset-done input
    always_comb begin
        rd_s1_d = RXRESETDONE;
        rd_s2_d = rd_s1_q;
    end

    // Next-state logic; loss of synchronized reset-done overrides everything
    always_comb begin
        state_d = ST_IDLE;
        if (state_q != ST_IDLE && !rd_s2_q) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:              state_d = rd_s2_q ? ST_ALIGN_RESET : ST_IDLE;
                ST_ALIGN_RESET:       state_d = (acnt_q == ALIGN_LIM) ? ST_WAIT_B4_SET_PHASE
                                                                      : ST_ALIGN_RESET;
                ST_WAIT_B4_SET_PHASE: state_d = (wcnt_q == WAIT_LIM) ? ST_PHASE_ALIGN
                                                                     : ST_WAIT_B4_SET_PHASE;
                ST_PHASE_ALIGN:       state_d = (scnt_q == SYNC_LIM) ? ST_READY
                                                                     : ST_PHASE_ALIGN;
                ST_READY:             state_d = RESYNC ? ST_IDLE : ST_READY;
                default:              state_d = ST_IDLE;
            endcase
        end
    end

    // Per-state counters run while the next state is their own, else clear
    always_comb begin
        acnt_d = (state_d == ST_ALIGN_RESET)       ? acnt_q + 5'd1  : '0;
        wcnt_d = (state_d == ST_WAIT_B4_SET_PHASE) ? wcnt_q + 6'd1  : '0;
        scnt_d = (state_d == ST_PHASE_ALIGN)       ? scnt_q + 16'd1 : '0;
    end

    // Outputs decoded from the next state so they register alongside it
    always_comb begin
        sync_done_d = 1'b0;
        dly_rst_d   = 1'b0;
        en_pma_d    = 1'b0;
        set_phase_d = 1'b0;
        case (state_d)
            ST_ALIGN_RESET:       dly_rst_d = 1'b1;
            ST_WAIT_B4_SET_PHASE: en_pma_d  = 1'b1;
            ST_PHASE_ALIGN: begin
                en_pma_d    = 1'b1;
                set_phase_d = 1'b1;
            end
            ST_READY: begin
                en_pma_d    = 1'b1;
                sync_done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Saturating count of exits from Ready, whatever the cause
    always_comb begin
        resync_cnt_d = resync_cnt_q;
        if (state_q == ST_READY && state_d != ST_READY && resync_cnt_q != 8'hFF) begin
            resync_cnt_d = resync_cnt_q + 8'd1;
        end
    end

    // State, counter, synchronizer and output registers
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q      <= ST_IDLE;
            rd_s1_q      <= 1'b0;
            rd_s2_q      <= 1'b0;
            acnt_q       <= '0;
            wcnt_q       <= '0;
            scnt_q       <= '0;
            sync_done_q  <= 1'b0;
            dly_rst_q    <= 1'b0;
            en_pma_q     <= 1'b0;
            set_phase_q  <= 1'b0;
            resync_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_s1_q      <= rd_s1_d;
            rd_s2_q      <= rd_s2_d;
            acnt_q       <= acnt_d;
            wcnt_q       <= wcnt_d;
            scnt_q       <= scnt_d;
            sync_done_q  <= sync_done_d;
            dly_rst_q    <= dly_rst_d;
            en_pma_q     <= en_pma_d;
            set_phase_q  <= set_phase_d;
            resync_cnt_q <= resync_cnt_d;
        end
    end

    assign SYNC_DONE         = sync_done_q;
    assign RXDLYALIGNRESET   = dly_rst_q;
    assign RXENPMAPHASEALIGN = en_pma_q;
    assign RXPMASETPHASE     = set_phase_q;
    assign RESYNC_CNT        = resync_cnt_q;

endmodule

// File: tb/tb_rx_sync_fsm.sv
// Testbench for rx_sync_fsm: one instance with default timing, one with short
// timing, both checked every cycle against a timeline model of the sequence.
module tb_rx_sync_fsm;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       rxrd0 = 1'b0, rs0 = 1'b0, rxrd1 = 1'b0, rs1 = 1'b0;
    logic       sd0, dly0, en0, sp0, sd1, dly1, en1, sp1;
    logic [7:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    // Reference model: synchronizer delay line plus "edges since sequence start"
    bit          m_rd1 [2];
    bit          m_rd2 [2];
    bit          m_act [2];
    int unsigned m_t   [2];
    int unsigned m_cnt [2];

    rx_sync_fsm #(.ALIGN_CNT(20), .WAIT_CNT(32), .SYNC_CNT(8192)) dut0 (
        .CLK(clk), .RST_B(rst_b), .RXRESETDONE(rxrd0), .RESYNC(rs0),
        .SYNC_DONE(sd0), .RXDLYALIGNRESET(dly0), .RXENPMAPHASEALIGN(en0),
        .RXPMASETPHASE(sp0), .RESYNC_CNT(cnt0)
    );

    rx_sync_fsm #(.ALIGN_CNT(2), .WAIT_CNT(3), .SYNC_CNT(4)) dut1 (
        .CLK(clk), .RST_B(rst_b), .RXRESETDONE(rxrd1), .RESYNC(rs1),
        .SYNC_DONE(sd1), .RXDLYALIGNRESET(dly1), .RXENPMAPHASEALIGN(en1),
        .RXPMASETPHASE(sp1), .RESYNC_CNT(cnt1)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] obs(input int i);
        if (i == 0) return {sd0, dly0, en0, sp0, cnt0};
        return {sd1, dly1, en1, sp1, cnt1};
    endfunction

    function automatic logic [11:0] expv(input int i);
        int unsigned a, w, s, t;
        logic sd, dl, en, sp;
        a  = (i == 0) ? 20 : 2;
        w  = (i == 0) ? 32 : 3;
        s  = (i == 0) ? 8192 : 4;
        t  = m_t[i];
        dl = m_act[i] && t <= a;
        en = m_act[i] && t > a;
        sp = m_act[i] && t > a + w && t <= a + w + s;
        sd = m_act[i] && t > a + w + s;
        return {sd, dl, en, sp, 8'(m_cnt[i])};
    endfunction

    task automatic model_clear(input int i);
        m_rd1[i] = 0; m_rd2[i] = 0; m_act[i] = 0; m_t[i] = 0; m_cnt[i] = 0;
    endtask

    task automatic model_upd(input int i, input logic rd, input logic rs);
        int unsigned total;
        bit ready;
        total = (i == 0) ? 20 + 32 + 8192 : 2 + 3 + 4;
        if (!rst_b) begin
            model_clear(i);
        end else begin
            ready = m_act[i] && m_t[i] > total;
            if (m_act[i]) begin
                if (!m_rd2[i] || (ready && rs)) begin
                    if (ready && m_cnt[i] < 255) m_cnt[i]++;
                    m_act[i] = 0;
                end else begin
                    m_t[i]++;
                end
            end else if (m_rd2[i]) begin
                m_act[i] = 1;
                m_t[i]   = 1;
            end
            m_rd2[i] = m_rd1[i];
            m_rd1[i] = rd;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
        model_upd(0, rxrd0, rs0);
        model_upd(1, rxrd1, rs1);
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        rxrd0 = 1'b0; rxrd1 = 1'b0; rs0 = 1'b0; rs1 = 1'b0;
        model_clear(0); model_clear(1);
        repeat (3) tick();
        rst_b = 1'b1;
        ecnt  = 0;
    endtask

    task automatic test_reset();
        #1;
        if (obs(0) !== 12'h000) begin
            errors++; $display("FAIL reset_async0 got %h want %h", obs(0), 12'h000);
        end
        checks++;
        if (obs(1) !== 12'h000) begin
            errors++; $display("FAIL reset_async1 got %h want %h", obs(1), 12'h000);
        end
        checks++;
        rxrd0 = 1'b1; rxrd1 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (obs(0) !== 12'h000) begin
                errors++; $display("FAIL reset_hold0 got %h want %h", obs(0), 12'h000);
            end
            checks++;
            if (obs(1) !== 12'h000) begin
                errors++; $display("FAIL reset_hold1 got %h want %h", obs(1), 12'h000);
            end
            checks++;
        end
    endtask

    // Full default sequence, optionally with RESYNC pulses in Align/Wait
    task automatic run_default(input int k0, input int p1, input int p2, input string tag);
        int dly_first = 0, dly_n = 0, sp_first = 0, sp_n = 0, sd_first = 0;
        do_reset();
        while (ecnt < k0 + 8250) begin
            if (ecnt == k0 - 1) rxrd0 = 1'b1;
            rs0 = (ecnt == p1 - 1 || ecnt == p2 - 1);
            tick();
            if (obs(0) !== expv(0)) begin
                errors++; $display("FAIL %s_cycle edge %0d got %h want %h", tag, ecnt, obs(0), expv(0));
            end
            checks++;
            if (dly0) begin dly_n++; if (dly_first == 0) dly_first = ecnt; end
            if (sp0)  begin sp_n++;  if (sp_first == 0)  sp_first  = ecnt; end
            if (sd0 && sd_first == 0) sd_first = ecnt;
        end
        rs0 = 1'b0;
        if (dly_first !== k0 + 2) begin
            errors++; $display("FAIL %s_dly_start got %0d want %0d", tag, dly_first, k0 + 2);
        end
        checks++;
        if (dly_n !== 20) begin
            errors++; $display("FAIL %s_dly_len got %0d want %0d", tag, dly_n, 20);
        end
        checks++;
        if (sp_first !== k0 + 54) begin
            errors++; $display("FAIL %s_sp_start got %0d want %0d", tag, sp_first, k0 + 54);
        end
        checks++;
        if (sp_n !== 8192) begin
            errors++; $display("FAIL %s_sp_len got %0d want %0d", tag, sp_n, 8192);
        end
        checks++;
        if (sd_first !== k0 + 8246) begin
            errors++; $display("FAIL %s_sd_start got %0d want %0d", tag, sd_first, k0 + 8246);
        end
        checks++;
        if (cnt0 !== 8'd0) begin
            errors++; $display("FAIL %s_cnt got %0d want %0d", tag, cnt0, 0);
        end
        checks++;
    endtask

    task automatic test_default_seq();
        run_default(10, -10, -10, "dflt");
    endtask

    task automatic test_resync_ignored();
        int k0, p1, p2;
        k0 = int'($urandom_range(20, 3));
        p1 = k0 + 3 + int'($urandom_range(18, 0));
        p2 = k0 + 23 + int'($urandom_range(30, 0));
        run_default(k0, p1, p2, "ign");
    endtask

    // Leaves dut0 in Ready with one exit counted, then aborts mid Phase_Align
    task automatic test_abort();
        int j, d, r, sp_n = 0;
        rs0 = 1'b1;
        tick();
        rs0 = 1'b0;
        j = ecnt;
        d = j + 53 + 99 + int'($urandom_range(5, 0));
        while (ecnt < d + 2) begin
            if (ecnt == d - 1) rxrd0 = 1'b0;
            tick();
            if (obs(0) !== expv(0)) begin
                errors++; $display("FAIL abort_cycle edge %0d got %h want %h", ecnt, obs(0), expv(0));
            end
            checks++;
            if (ecnt == d + 1 && sp0 !== 1'b1) begin
                errors++; $display("FAIL abort_early sp got %b want %b", sp0, 1'b1);
            end
            if (ecnt == d + 1) checks++;
        end
        if ({sd0, dly0, en0, sp0} !== 4'b0000) begin
            errors++; $display("FAIL abort_outs got %b want %b", {sd0, dly0, en0, sp0}, 4'b0000);
        end
        checks++;
        if (cnt0 !== 8'd1) begin
            errors++; $display("FAIL abort_cnt got %0d want %0d", cnt0, 1);
        end
        checks++;
        r = ecnt + int'($urandom_range(5, 1));
        for (int n = 0; n < 8400 && !sd0; n++) begin
            if (ecnt == r) rxrd0 = 1'b1;
            tick();
            if (obs(0) !== expv(0)) begin
                errors++; $display("FAIL abort_re edge %0d got %h want %h", ecnt, obs(0), expv(0));
            end
            checks++;
            if (sp0) sp_n++;
        end
        if (sp_n !== 8192 || sd0 !== 1'b1) begin
            errors++; $display("FAIL abort_restart sp_len got %0d sd %b want %0d sd 1", sp_n, sd0, 8192);
        end
        checks++;
    endtask

    task automatic test_resync_small();
        int a_n = 0, w_n = 0, s_n = 0;
        do_reset();
        rxrd1 = 1'b1;
        for (int n = 0; n < 40 && !sd1; n++) begin
            tick();
            if (obs(1) !== expv(1)) begin
                errors++; $display("FAIL rs_up edge %0d got %h want %h", ecnt, obs(1), expv(1));
            end
            checks++;
        end
        repeat (int'($urandom_range(4, 0))) tick();
        rs1 = 1'b1;
        tick();
        rs1 = 1'b0;
        if (sd1 !== 1'b0 || cnt1 !== 8'd1) begin
            errors++; $display("FAIL rs_exit sd %b cnt %0d want sd 0 cnt 1", sd1, cnt1);
        end
        checks++;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (obs(1) !== expv(1)) begin
                errors++; $display("FAIL rs_seq edge %0d got %h want %h", ecnt, obs(1), expv(1));
            end
            checks++;
            if (dly1 && !en1) a_n++;
            if (en1 && !sp1 && !sd1 && !dly1) w_n++;
            if (sp1) s_n++;
        end
        if (a_n !== 2 || w_n !== 3 || s_n !== 4 || sd1 !== 1'b1) begin
            errors++; $display("FAIL rs_shape got a%0d w%0d s%0d sd%b want a2 w3 s4 sd1", a_n, w_n, s_n, sd1);
        end
        checks++;
    endtask

    task automatic test_resync_with_drop();
        rxrd1 = 1'b0;
        tick();
        tick();
        if (sd1 !== 1'b1) begin
            errors++; $display("FAIL drop_early sd got %b want %b", sd1, 1'b1);
        end
        checks++;
        rs1 = 1'b1;
        tick();
        rs1 = 1'b0;
        if (sd1 !== 1'b0 || cnt1 !== 8'd2) begin
            errors++; $display("FAIL drop_both sd %b cnt %0d want sd 0 cnt 2", sd1, cnt1);
        end
        checks++;
        repeat (3) tick();
        rxrd1 = 1'b1;
        for (int n = 0; n < 30 && !sd1; n++) begin
            tick();
            if (obs(1) !== expv(1)) begin
                errors++; $display("FAIL drop_re edge %0d got %h want %h", ecnt, obs(1), expv(1));
            end
            checks++;
        end
    endtask

    task automatic test_saturation();
        for (int it = 0; it < 300; it++) begin
            for (int n = 0; n < 30 && !sd1; n++) begin
                tick();
                if (obs(1) !== expv(1)) begin
                    errors++; $display("FAIL sat_cycle it %0d got %h want %h", it, obs(1), expv(1));
                end
                checks++;
            end
            repeat (int'($urandom_range(3, 0))) tick();
            rs1 = 1'b1;
            tick();
            rs1 = 1'b0;
            if (obs(1) !== expv(1)) begin
                errors++; $display("FAIL sat_exit it %0d got %h want %h", it, obs(1), expv(1));
            end
            checks++;
        end
        if (cnt1 !== 8'd255) begin
            errors++; $display("FAIL sat_final got %0d want %0d", cnt1, 255);
        end
        checks++;
    endtask

    task automatic test_async_reset();
        bit found = 0;
        for (int n = 0; n < 30 && !found; n++) begin
            tick();
            found = en1 && !sp1 && !sd1 && !dly1;
        end
        if (!found) begin
            errors++; $display("FAIL arst_reach got %b want %b", found, 1'b1);
        end
        checks++;
        #3;
        rst_b = 1'b0;
        #1;
        if (obs(1) !== 12'h000) begin
            errors++; $display("FAIL arst_clear1 got %h want %h", obs(1), 12'h000);
        end
        checks++;
        if (obs(0) !== 12'h000) begin
            errors++; $display("FAIL arst_clear0 got %h want %h", obs(0), 12'h000);
        end
        checks++;
        model_clear(0); model_clear(1);
        repeat (2) tick();
        rst_b = 1'b1;
        ecnt  = 0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            if (dly1 !== (n == 3)) begin
                errors++; $display("FAIL arst_rel edge %0d dly got %b want %b", n, dly1, n == 3);
            end
            checks++;
            if (obs(1) !== expv(1)) begin
                errors++; $display("FAIL arst_cycle edge %0d got %h want %h", n, obs(1), expv(1));
            end
            checks++;
        end
    endtask

    initial begin
        model_clear(0); model_clear(1);
        test_reset();
        test_default_seq();
        test_resync_ignored();
        test_abort();
        test_resync_small();
        test_resync_with_drop();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
